wb_timer: RTL and testbench
===========================

WB_TIMER -- requirements
Module: wb_timer

Interface
REQ-001 SHALL have parameter PRESCALE_RESET, default 16'h0000: reset value of the PRESCALE register.
REQ-002 SHALL have parameter CTRL_RESET, default 2'b00: reset value of CTRL[1:0].
REQ-003 wb_clk_i  in  1  single clock; all logic rises on this edge.
REQ-004 wb_rst_ni  in  1  reset, synchronous, active-low.
REQ-005 wb_adr_i  in  3  word address (byte address bits [4:2]).
REQ-006 wb_dat_i  in  32  write data.
REQ-007 wb_sel_i  in  4  byte enables for writes.
REQ-008 wb_we_i  in  1  write strobe.
REQ-009 wb_cyc_i, wb_stb_i  in  1 each  Wishbone cycle and strobe.
REQ-010 wb_cti_i  in  3  and wb_bte_i  in  2  accepted and ignored; every access is treated as classic.
REQ-011 wb_dat_o  out  32  read data.
REQ-012 wb_ack_o  out  1  transfer acknowledge.
REQ-013 wb_err_o  out  1  error for an unmapped address.
REQ-014 irq_o  out  1  timer interrupt, level.

Function
REQ-015 Register map by wb_adr_i:
- 0 MTIME_LO
- 1 MTIME_HI
- 2 CMP_LO
- 3 CMP_HI
- 4 CTRL (bit0 EN, bit1 IRQ_EN)
- 5 PRESCALE [15:0]
- 6 STATUS (bit0 PEND, write-1-to-clear)
- 7 unmapped
REQ-016 Handshake:
- When wb_cyc_i&wb_stb_i is high and no response was issued in the previous cycle, exactly one of wb_ack_o/wb_err_o SHALL go high in the next cycle, for one cycle.
- A strobe held across that response SHALL NOT produce a second response in the following cycle.
- Result: one response per two cycles per held strobe.
REQ-017 Address 7 SHALL return wb_err_o (no ack) and SHALL have no side effects; wb_dat_o SHALL be 0.
REQ-018 Writes SHALL take effect at the same edge that raises wb_ack_o, honouring wb_sel_i per byte; bits beyond a register's width SHALL be ignored.
REQ-019 Reads SHALL present data on wb_dat_o in the ack cycle; unused bits read 0; wb_dat_o SHALL be 0 when no ack.
REQ-020 Prescaler:
- presc_cnt[15:0] SHALL increment each cycle while EN=1.
- When presc_cnt==PRESCALE: tick for one cycle and presc_cnt<=0.
- EN=0 SHALL hold presc_cnt and mtime.
REQ-021 On tick, mtime[63:0] SHALL increment by 1, wrapping 2^64-1 -> 0.
REQ-022 A write to PRESCALE SHALL also clear presc_cnt to 0 at that edge.
REQ-023 A bus write to MTIME_LO/HI SHALL win over a simultaneous tick; only the written bytes change and the other half is left unincremented that cycle.
REQ-024 A read of MTIME_LO SHALL capture mtime[63:32] into a shadow register at the ack edge.
REQ-025 A read of MTIME_HI SHALL return the shadow register, not the live value.
REQ-026 PEND SHALL be set at any edge where mtime>=cmp (64-bit unsigned, registered values), independent of EN; it stays set until cleared.
REQ-027 Writing STATUS with bit0=1 (sel[0]=1) SHALL clear PEND.
- If the compare is true in the same cycle, set SHALL win, so PEND stays 1.
REQ-028 irq_o SHALL be registered and equal PEND&IRQ_EN, one cycle after either changes.
REQ-029 Writing CMP SHALL NOT clear PEND by itself.

Reset
REQ-030 While wb_rst_ni=0 at an edge, the following SHALL reset:
- mtime=0, cmp=64'hFFFF_FFFF_FFFF_FFFF, shadow=0
- CTRL=CTRL_RESET, PRESCALE=PRESCALE_RESET, presc_cnt=0, PEND=0
- wb_ack_o=0, wb_err_o=0, wb_dat_o=0, irq_o=0
REQ-031 Reset asserted mid-transfer SHALL drop any pending response; no ack/err SHALL be issued for that strobe.

Verification
REQ-032 Reset, CTRL<=1, PRESCALE=0, wait 10 cycles -> MTIME_LO reads about 10, ack exactly 1 cycle after stb, no err.
REQ-033 PRESCALE<=3, EN=1 -> mtime increments once per 4 cycles; write PRESCALE mid-count -> next tick 4 cycles after that write.
REQ-034 MTIME<=64'h0000_0000_FFFF_FFFE, EN=1, PRESCALE=0 -> two ticks later MTIME_LO=0, MTIME_HI (via shadow after LO read)=1.
REQ-035 CMP<=20, IRQ_EN=1, EN=1 -> PEND sets when mtime reaches 20, irq_o high one cycle later; STATUS<=1 -> PEND stays 1 (still >=).
- Then CMP<=all-ones, STATUS<=1 -> PEND=0, irq_o=0.
REQ-036 Access to address 7 -> wb_err_o one cycle, wb_ack_o stays 0, no register changes.
- Write CTRL with sel=4'b0000 -> ack, CTRL unchanged.
REQ-037 Held strobe for 6 cycles -> exactly 3 responses, alternate cycles; reset asserted in the cycle after a strobe -> no response.

Source files
------------

// File: rtl/wb_timer.sv
// Wishbone-attached 64-bit machine timer with prescaler, 64-bit compare,
// sticky pending flag and level interrupt.
module wb_timer #(
  parameter logic [15:0] PRESCALE_RESET = 16'h0000,
  parameter logic [1:0]  CTRL_RESET     = 2'b00
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic [2:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic [2:0]  wb_cti_i,
  input  logic [1:0]  wb_bte_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        irq_o
);

  typedef enum logic [2:0] {
    ADR_MTIME_LO = 3'd0,
    ADR_MTIME_HI = 3'd1,
    ADR_CMP_LO   = 3'd2,
    ADR_CMP_HI   = 3'd3,
    ADR_CTRL     = 3'd4,
    ADR_PRESCALE = 3'd5,
    ADR_STATUS   = 3'd6,
    ADR_UNMAPPED = 3'd7
  } reg_adr_e;

  function automatic logic [31:0] byte_merge(input logic [31:0] cur,
                                             input logic [31:0] wdat,
                                             input logic [3:0]  sel);
    logic [31:0] res;
    res = cur;
    for (int b = 0; b < 4; b++)
      if (sel[b]) res[8*b +: 8] = wdat[8*b +: 8];
    return res;
  endfunction

  logic [63:0] mtime;
  logic [63:0] cmp;
  logic [31:0] shadow;
  logic [1:0]  ctrl;
  logic [15:0] prescale;
  logic [15:0] presc_cnt;
  logic        pend;
  logic [31:0] rdata;

  reg_adr_e adr;
  logic     req, rd, wr, tick, cmp_hit, pend_clr;
  logic     unused_ok;

  // Burst signalling is not supported; every access behaves as classic.
  assign unused_ok = ^{wb_cti_i, wb_bte_i};

  assign adr = reg_adr_e'(wb_adr_i);
  // A response issued last cycle blocks a new one, so a held strobe is
  // answered on alternate cycles.
  assign req      = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
  assign rd       = req & ~wb_we_i;
  assign wr       = req &  wb_we_i;
  assign tick     = ctrl[0] & (presc_cnt == prescale);
  assign cmp_hit  = (mtime >= cmp);
  assign pend_clr = wr & (adr == ADR_STATUS) & wb_sel_i[0] & wb_dat_i[0];

  // NOTE: every signal assigned in always_comb gets a default first so that
  // no path leaves it unassigned and a latch is never inferred.
  always_comb begin
    rdata = '0;
    case (adr)
      ADR_MTIME_LO: rdata = mtime[31:0];
      ADR_MTIME_HI: rdata = shadow;
      ADR_CMP_LO:   rdata = cmp[31:0];
      ADR_CMP_HI:   rdata = cmp[63:32];
      ADR_CTRL:     rdata = {30'd0, ctrl};
      ADR_PRESCALE: rdata = {16'd0, prescale};
      ADR_STATUS:   rdata = {31'd0, pend};
      default:      rdata = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side below sees the values from before this edge.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      mtime     <= '0;
      cmp       <= '1;
      shadow    <= '0;
      ctrl      <= CTRL_RESET;
      prescale  <= PRESCALE_RESET;
      presc_cnt <= '0;
      pend      <= 1'b0;
      wb_ack_o  <= 1'b0;
      wb_err_o  <= 1'b0;
      wb_dat_o  <= '0;
      irq_o     <= 1'b0;
    end else begin
      wb_ack_o <= req & (adr != ADR_UNMAPPED);
      wb_err_o <= req & (adr == ADR_UNMAPPED);
      wb_dat_o <= rd ? rdata : '0;

      if (rd && adr == ADR_MTIME_LO) shadow <= mtime[63:32];

      // A bus write to either half suppresses the tick for the whole counter.
      if (wr && adr == ADR_MTIME_LO)
        mtime[31:0] <= byte_merge(mtime[31:0], wb_dat_i, wb_sel_i);
      else if (wr && adr == ADR_MTIME_HI)
        mtime[63:32] <= byte_merge(mtime[63:32], wb_dat_i, wb_sel_i);
      else if (tick)
        mtime <= mtime + 64'd1;

      if (wr && adr == ADR_CMP_LO) cmp[31:0]  <= byte_merge(cmp[31:0], wb_dat_i, wb_sel_i);
      if (wr && adr == ADR_CMP_HI) cmp[63:32] <= byte_merge(cmp[63:32], wb_dat_i, wb_sel_i);

      if (wr && adr == ADR_CTRL && wb_sel_i[0]) ctrl <= wb_dat_i[1:0];

      if (wr && adr == ADR_PRESCALE) begin
        if (wb_sel_i[0]) prescale[7:0]  <= wb_dat_i[7:0];
        if (wb_sel_i[1]) prescale[15:8] <= wb_dat_i[15:8];
        presc_cnt <= '0;
      end else if (tick) begin
        presc_cnt <= '0;
      end else if (ctrl[0]) begin
        presc_cnt <= presc_cnt + 16'd1;
      end

      pend  <= cmp_hit | (pend & ~pend_clr);
      irq_o <= pend & ctrl[1];
    end
  end

endmodule

// File: tb/tb_wb_timer.sv
// Directed bench for wb_timer: table of register accesses plus hand-timed
// sequences for prescaler, wrap, compare/interrupt and handshake corners.
module tb_wb_timer;

  localparam logic [2:0] A_LO = 3'd0, A_HI = 3'd1, A_CLO = 3'd2, A_CHI = 3'd3,
                         A_CTRL = 3'd4, A_PRE = 3'd5, A_STAT = 3'd6, A_BAD = 3'd7;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  adr;
  logic [31:0] dat_i;
  logic [3:0]  sel;
  logic        we, cyc, stb;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic [31:0] dat_o;
  logic        ack, err, irq;

  int n_cmp  = 0;
  int n_fail = 0;

  wb_timer dut (
    .wb_clk_i (clk),
    .wb_rst_ni(rst_n),
    .wb_adr_i (adr),
    .wb_dat_i (dat_i),
    .wb_sel_i (sel),
    .wb_we_i  (we),
    .wb_cyc_i (cyc),
    .wb_stb_i (stb),
    .wb_cti_i (cti),
    .wb_bte_i (bte),
    .wb_dat_o (dat_o),
    .wb_ack_o (ack),
    .wb_err_o (err),
    .irq_o    (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  adr;
    logic        we;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp_dat;
    logic        exp_ack;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t rdv(string n, logic [2:0] a, logic [31:0] e);
    return '{n, a, 1'b0, 32'h0, 4'hF, e, 1'b1, 1'b0};
  endfunction

  function automatic vec_t wrv(string n, logic [2:0] a, logic [31:0] d, logic [3:0] s);
    return '{n, a, 1'b1, d, s, 32'h0, 1'b1, 1'b0};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One access: strobe for one cycle, sample the response cycle, then idle a cycle.
  task automatic wb_xfer(input logic [2:0] a, input logic w, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] r,
                         output logic ak, output logic er);
    @(negedge clk);
    adr = a; we = w; dat_i = d; sel = s; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    r = dat_o; ak = ack; er = err;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wb_write(input string n, input logic [2:0] a, input logic [31:0] d,
                          input logic [3:0] s);
    logic [31:0] r;
    logic ak, er;
    wb_xfer(a, 1'b1, d, s, r, ak, er);
    check(n, 64'({ak, er}), 64'(2'b10));
  endtask

  task automatic wb_read(input string n, input logic [2:0] a, input logic [31:0] e);
    logic [31:0] r;
    logic ak, er;
    wb_xfer(a, 1'b0, 32'h0, 4'hF, r, ak, er);
    check(n, 64'({ak, er, r}), 64'({1'b1, 1'b0, e}));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic ak, er;
    int first_irq, resp_cnt;
    logic [31:0] exp_lo[7];

    rst_n = 1'b0; adr = '0; dat_i = '0; sel = '0; we = 1'b0;
    cyc = 1'b0; stb = 1'b0; cti = 3'b111; bte = 2'b11;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 64'({ack, err, irq, dat_o}), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    vecs.push_back(rdv("rst_ctrl",     A_CTRL, 32'h0));
    vecs.push_back(rdv("rst_prescale", A_PRE,  32'h0));
    vecs.push_back(rdv("rst_status",   A_STAT, 32'h0));
    vecs.push_back(rdv("rst_cmp_lo",   A_CLO,  32'hFFFF_FFFF));
    vecs.push_back(rdv("rst_cmp_hi",   A_CHI,  32'hFFFF_FFFF));
    vecs.push_back(rdv("rst_mtime_lo", A_LO,   32'h0));
    vecs.push_back(rdv("rst_mtime_hi", A_HI,   32'h0));
    vecs.push_back(wrv("wr_cmp_lo_sel5", A_CLO, 32'h1234_5678, 4'b0101));
    vecs.push_back(rdv("rd_cmp_lo_sel5", A_CLO, 32'hFF34_FF78));
    vecs.push_back(wrv("wr_presc_full", A_PRE, 32'hABCD_1234, 4'hF));
    vecs.push_back(rdv("rd_presc_trunc", A_PRE, 32'h0000_1234));
    vecs.push_back(wrv("wr_presc_byte1", A_PRE, 32'h0000_5600, 4'b0010));
    vecs.push_back(rdv("rd_presc_byte1", A_PRE, 32'h0000_5634));
    vecs.push_back('{"rd_unmapped", A_BAD, 1'b0, 32'h0, 4'hF, 32'h0, 1'b0, 1'b1});
    vecs.push_back('{"wr_unmapped", A_BAD, 1'b1, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b0, 1'b1});
    vecs.push_back(rdv("presc_after_bad", A_PRE, 32'h0000_5634));
    vecs.push_back(rdv("ctrl_after_bad", A_CTRL, 32'h0));
    vecs.push_back(wrv("wr_ctrl_sel0", A_CTRL, 32'h0000_0003, 4'b0000));
    vecs.push_back(rdv("rd_ctrl_sel0", A_CTRL, 32'h0));
    vecs.push_back(wrv("wr_ctrl_wide", A_CTRL, 32'hFFFF_FFFE, 4'b0001));
    vecs.push_back(rdv("rd_ctrl_wide", A_CTRL, 32'h0000_0002));
    vecs.push_back(wrv("wr_ctrl_off", A_CTRL, 32'h0, 4'hF));
    vecs.push_back(wrv("wr_mtlo_b3", A_LO, 32'hAABB_CCDD, 4'b1000));
    vecs.push_back(rdv("rd_mtlo_b3", A_LO, 32'hAA00_0000));
    vecs.push_back(wrv("wr_mthi_b0", A_HI, 32'h0000_0011, 4'b0001));
    vecs.push_back(rdv("rd_mthi_stale", A_HI, 32'h0));
    vecs.push_back(rdv("rd_mtlo_again", A_LO, 32'hAA00_0000));
    vecs.push_back(rdv("rd_mthi_shadow", A_HI, 32'h0000_0011));
    vecs.push_back(wrv("clr_mtlo", A_LO, 32'h0, 4'hF));
    vecs.push_back(wrv("clr_mthi", A_HI, 32'h0, 4'hF));
    vecs.push_back(wrv("restore_cmp_lo", A_CLO, 32'hFFFF_FFFF, 4'hF));
    vecs.push_back(wrv("restore_presc", A_PRE, 32'h0, 4'hF));
    vecs.push_back(rdv("status_clean", A_STAT, 32'h0));

    for (int i = 0; i < vecs.size(); i++) begin
      wb_xfer(vecs[i].adr, vecs[i].we, vecs[i].dat, vecs[i].sel, r, ak, er);
      if (vecs[i].we)
        check(vecs[i].name, 64'({ak, er}), 64'({vecs[i].exp_ack, vecs[i].exp_err}));
      else
        check(vecs[i].name, 64'({ak, er, r}),
              64'({vecs[i].exp_ack, vecs[i].exp_err, vecs[i].exp_dat}));
    end

    // Prescale 0: one tick per cycle after enabling.
    wb_write("en_presc0", A_CTRL, 32'h1, 4'hF);
    idle(9);
    wb_read("mtime_after_10", A_LO, 32'd10);

    // Prescale 3: one tick every 4 cycles.
    wb_write("stop_a", A_CTRL, 32'h0, 4'hF);
    wb_write("zero_lo_a", A_LO, 32'h0, 4'hF);
    wb_write("presc3", A_PRE, 32'h3, 4'hF);
    wb_write("en_presc3", A_CTRL, 32'h1, 4'hF);
    exp_lo = '{32'd0, 32'd0, 32'd1, 32'd1, 32'd2, 32'd2, 32'd3};
    for (int j = 0; j < 7; j++) wb_read("presc3_rate", A_LO, exp_lo[j]);
    idle(2);
    wb_write("presc3_midcount", A_PRE, 32'h3, 4'hF);
    wb_read("after_presc_wr_1", A_LO, 32'd4);
    wb_read("after_presc_wr_2", A_LO, 32'd4);
    wb_read("after_presc_wr_3", A_LO, 32'd5);

    // Carry from low into high word.
    wb_write("stop_b", A_CTRL, 32'h0, 4'hF);
    wb_write("presc0_b", A_PRE, 32'h0, 4'hF);
    wb_write("hi0_b", A_HI, 32'h0, 4'hF);
    wb_write("lo_fffe", A_LO, 32'hFFFF_FFFE, 4'hF);
    wb_write("en_b", A_CTRL, 32'h1, 4'hF);
    idle(1);
    wb_read("carry_lo", A_LO, 32'h0);
    wb_read("carry_hi", A_HI, 32'h1);

    // Full 64-bit wrap; all-ones also meets the all-ones compare.
    wb_write("stop_c", A_CTRL, 32'h0, 4'hF);
    wb_write("lo_ones", A_LO, 32'hFFFF_FFFF, 4'hF);
    wb_write("hi_ones", A_HI, 32'hFFFF_FFFF, 4'hF);
    wb_write("en_c", A_CTRL, 32'h1, 4'hF);
    wb_read("wrap_lo", A_LO, 32'h0);
    wb_read("wrap_hi", A_HI, 32'h0);
    wb_read("pend_sticky", A_STAT, 32'h1);
    wb_write("stop_d", A_CTRL, 32'h0, 4'hF);
    wb_write("clr_pend_d", A_STAT, 32'h1, 4'h1);
    wb_read("pend_cleared_d", A_STAT, 32'h0);

    // Compare at 20 with interrupt enabled.
    wb_write("lo0_e", A_LO, 32'h0, 4'hF);
    wb_write("cmp_hi0", A_CHI, 32'h0, 4'hF);
    wb_write("cmp_lo20", A_CLO, 32'd20, 4'hF);
    wb_write("en_irq", A_CTRL, 32'h3, 4'hF);
    first_irq = 0;
    for (int i = 1; i <= 60 && first_irq == 0; i++) begin
      @(posedge clk); #1;
      if (irq) first_irq = i;
    end
    check("irq_latency", 64'(first_irq), 64'd21);
    wb_write("clr_while_hit", A_STAT, 32'h1, 4'h1);
    wb_read("pend_set_wins", A_STAT, 32'h1);
    check("irq_still_high", 64'(irq), 64'd1);
    wb_write("cmp_lo_ones", A_CLO, 32'hFFFF_FFFF, 4'hF);
    wb_write("cmp_hi_ones", A_CHI, 32'hFFFF_FFFF, 4'hF);
    wb_read("pend_kept_by_cmp_wr", A_STAT, 32'h1);
    wb_write("clr_pend_e", A_STAT, 32'h1, 4'h1);
    wb_read("pend_cleared_e", A_STAT, 32'h0);
    check("irq_low", 64'(irq), 64'd0);
    wb_write("stop_e", A_CTRL, 32'h0, 4'hF);

    // Held strobe: responses on alternate cycles.
    @(negedge clk);
    adr = A_CTRL; we = 1'b0; cyc = 1'b1; stb = 1'b1;
    resp_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("held_resp", 64'({ack, err}), 64'({(i % 2) == 0, 1'b0}));
      if (ack || err) resp_cnt++;
    end
    cyc = 1'b0; stb = 1'b0;
    check("held_total", 64'(resp_cnt), 64'd3);

    // Reset at the edge that would answer a strobe.
    @(negedge clk);
    adr = A_CTRL; we = 1'b0; cyc = 1'b1; stb = 1'b1; rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst_drops_resp", 64'({ack, err}), 64'h0);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    resp_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (ack || err) resp_cnt++;
    end
    check("no_late_resp", 64'(resp_cnt), 64'd0);
    wb_read("ctrl_after_reset", A_CTRL, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
